jhson_monitor: RTL and testbench
================================

# jhson_monitor

Downstream checker/decoder for the 4-bit Johnson counter output. It samples the 8-state Johnson code every clock and decodes it to a binary phase index and a one-hot phase vector. It verifies that the sequence only holds or advances by one legal step, and acquires lock after a programmable run of clean advances. Once locked, it counts completed revolutions and records sequence errors for the status/debug path.

## Interface
- `LOCK_CNT`, default 4: consecutive legal advances required to enter LOCK. Legal range 1..15.
- `REV_W`, default 8: width of the revolution counter.
- `clk` input, 1 bit: system clock. All logic is rising-edge.
- `n_rst` input, 1 bit: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `in_a` input, 4 bits: Johnson code from the counter stage.
- `clr` input, 1 bit: synchronous clear of `rev_cnt`, `err_cnt` and `err_sticky`.
- `phase` output, 3 bits: decoded phase index of the last sample.
- `phase_oh` output, 8 bits: one-hot of `phase`. All zeros when the last sample was illegal.
- `step` output, 1 bit: one-cycle pulse on a legal advance.
- `rev` output, 1 bit: one-cycle pulse on a revolution completed while locked.
- `rev_cnt` output, REV_W bits: revolution count. Wraps modulo 2^REV_W.
- `lock` output, 1 bit: high in LOCK state.
- `err` output, 1 bit: one-cycle pulse on a sequence error while locked.
- `err_sticky` output, 1 bit: set by `err`, held until `clr`.
- `err_cnt` output, 8 bits: error count. Saturates at 255.

## Operation
- **Code table (phase 0..7):** 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
  - The other 8 codes are illegal.
  - The successor of phase 7 is phase 0.
- **Sampling:** each edge registers `in_a` into `code_q` and legality into `vld_q`.
- **Classification:** each edge classifies the new sample against `code_q`.
  - *hold:* same code, legal.
  - *advance:* legal, and the successor of `code_q`, with `vld_q`=1.
  - *error:* any other case, including an illegal code, a skip, a backward step, or any move from an illegal `code_q`.
- **Decode outputs:**
  - `phase`/`phase_oh` update every edge from the new sample.
  - On an illegal sample, `phase` holds its previous value and `phase_oh` = 0.
- **FSM states:** SEARCH (reset state), ACQ, LOCK. The run counter is 4 bits.
  - SEARCH: legal sample → ACQ with run=0. Illegal sample → stay.
  - ACQ: advance → run+1. When run+1 == LOCK_CNT → LOCK. Hold → no change. Error → SEARCH, run=0.
  - LOCK: advance/hold → stay. Error → SEARCH, run=0, `err` pulse.
- **Step pulse:** `step`=1 for every advance in ACQ or LOCK.
- **Revolution pulse:** `rev`=1 and `rev_cnt`+1 on an advance 0001→0000 in LOCK only.
- **Error counting:**
  - Errors in SEARCH or ACQ are not counted.
  - `err` sets `err_sticky` and increments `err_cnt` (saturating).
- **`clr` collision rule:** on a same-cycle `clr` plus event, the event wins. The counter is cleared and then the event is applied:
  - `rev_cnt`=1 for a revolution event.
  - `err_cnt`=1 and `err_sticky`=1 for an error event.

## Timing
- **Reset values:**
  - `phase`=0, `phase_oh`=0, `step`=0, `rev`=0, `rev_cnt`=0.
  - `lock`=0, `err`=0, `err_sticky`=0, `err_cnt`=0.
  - State SEARCH, `code_q`=0000, `vld_q`=0.
- **Latency:** all outputs are registered, one cycle after `in_a` is sampled. There is no combinational in→out path.
- **Lock timing:** a free-running counter starting at 0000 after reset gives `lock`=1 after edge 5 (LOCK_CNT=4). The first `rev` follows edge 9.
- **Lock loss:** `lock` drops on the same edge that produces `err`.
- **Reassertion after an error:**
  - If the erroneous code is itself legal, the next edge enters ACQ.
  - Re-lock takes 1+LOCK_CNT further edges.
- **Reset mid-operation:** asynchronous return to all reset values. There is no pulse on reset release.
- **Back-to-back errors:** one `err` per offending edge, but only while in LOCK. The second error finds the FSM in SEARCH and is not counted.

## Test plan
- **Lock acquisition:** reset, then drive the legal sequence from 0000 every cycle → `lock`=1 after edge 5, `step` high edges 2–9, `rev`=1 and `rev_cnt`=1 after edge 9, `err_cnt`=0.
- **Skip error:** locked; at phase 1100 drive 1111 → `err` pulse, `lock`=0, `err_cnt`=1, `err_sticky`=1, `phase`=4. Resume the sequence → `lock`=1 again after 5 edges.
- **Illegal code:** locked; drive 1010 for one cycle → `phase_oh`=0, `phase` held, `err`=1, state SEARCH. Then 0000 → ACQ.
- **Holds and LOCK_CNT=1:** with LOCK_CNT=1, repeat each legal code 3 cycles → no error, `step` once per code change, `lock` after the first advance.
- **Counter boundaries:** REV_W=2, 5 revolutions → `rev_cnt`=1 (wrap). Force 260 locked errors with re-lock between them → `err_cnt`=255. Assert `clr` together with a `rev` event → `rev_cnt`=1.
- **Reset mid-run:** pulse `n_rst` low mid-revolution → all outputs 0 immediately. Re-acquisition timing is identical to the lock-acquisition scenario.

Source files
------------

// File: rtl/jhson_monitor_if.sv
// Bus between the Johnson counter stage and its downstream monitor.
// The master side drives the sampled code and the status clear.
// The slave side, the monitor, returns the decode and the lock/revolution/error status.
interface jhson_monitor_if #(
    parameter int REV_W = 8
);
    logic [3:0]       in_a;
    logic             clr;
    logic [2:0]       phase;
    logic [7:0]       phase_oh;
    logic             step;
    logic             rev;
    logic [REV_W-1:0] rev_cnt;
    logic             lock;
    logic             err;
    logic             err_sticky;
    logic [7:0]       err_cnt;

    modport master (
        output in_a, clr,
        input  phase, phase_oh, step, rev, rev_cnt, lock, err, err_sticky, err_cnt
    );

    modport slave (
        input  in_a, clr,
        output phase, phase_oh, step, rev, rev_cnt, lock, err, err_sticky, err_cnt
    );
endinterface

// File: rtl/jhson_monitor.sv
// Johnson-code monitor.
// Decodes the 4-bit, 8-state Johnson code to a phase index and a one-hot vector.
// Checks that the sequence only holds or advances by one step, and locks after
// LOCK_CNT clean advances. While locked it counts revolutions and sequence errors.
module jhson_monitor #(
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 8
) (
    input logic             clk,
    input logic             n_rst,
    jhson_monitor_if.slave  bus
);
    typedef enum logic [1:0] {SEARCH, ACQ, LOCK} state_t;

    localparam logic [3:0] LOCK_RUN = 4'(LOCK_CNT);

    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b1000, 4'b1100, 4'b1110,
            4'b1111, 4'b0111, 4'b0011, 4'b0001: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] to_phase(input logic [3:0] c);
        case (c)
            4'b1000: to_phase = 3'd1;
            4'b1100: to_phase = 3'd2;
            4'b1110: to_phase = 3'd3;
            4'b1111: to_phase = 3'd4;
            4'b0111: to_phase = 3'd5;
            4'b0011: to_phase = 3'd6;
            4'b0001: to_phase = 3'd7;
            default: to_phase = 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic [3:0]       code_q;
    logic             vld_q;
    logic             step_d, rev_d, err_d;

    logic [2:0]       phase_q;
    logic [7:0]       phase_oh_q;
    logic             step_q, rev_q, err_q, err_sticky_q;
    logic [REV_W-1:0] rev_cnt_q;
    logic [7:0]       err_cnt_q;

    logic             legal_new;
    logic [2:0]       ph_new, ph_old;
    logic             is_hold, is_adv;

    // Classify the incoming sample against the previously registered one.
    // The 3-bit phase compare wraps, so phase 7 -> 0 counts as an advance.
    assign legal_new = is_legal(bus.in_a);
    assign ph_new    = to_phase(bus.in_a);
    assign ph_old    = to_phase(code_q);
    assign is_hold   = legal_new && (bus.in_a == code_q);
    assign is_adv    = legal_new && vld_q && (ph_new == ph_old + 3'd1);

    // State and run-counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= SEARCH;
            run_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Next-state logic and event strobes. Only errors seen while locked are reported.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        step_d  = 1'b0;
        rev_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            SEARCH: begin
                if (legal_new) begin
                    state_d = ACQ;
                    run_d   = 4'd0;
                end
            end
            ACQ: begin
                if (is_adv) begin
                    step_d = 1'b1;
                    run_d  = run_q + 4'd1;
                    if (run_q + 4'd1 == LOCK_RUN) state_d = LOCK;
                end else if (!is_hold) begin
                    state_d = SEARCH;
                    run_d   = 4'd0;
                end
            end
            LOCK: begin
                if (is_adv) begin
                    step_d = 1'b1;
                    rev_d  = (ph_new == 3'd0);
                end else if (!is_hold) begin
                    state_d = SEARCH;
                    run_d   = 4'd0;
                    err_d   = 1'b1;
                end
            end
            default: begin
                state_d = SEARCH;
                run_d   = 4'd0;
            end
        endcase
    end

    // Sample register: the raw code and its legality, used by the next classification.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            code_q <= 4'b0000;
            vld_q  <= 1'b0;
        end else begin
            code_q <= bus.in_a;
            vld_q  <= legal_new;
        end
    end

    // Registered decode and event pulses. The phase index holds across an illegal sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase_q    <= 3'd0;
            phase_oh_q <= 8'd0;
            step_q     <= 1'b0;
            rev_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (legal_new) phase_q <= ph_new;
            phase_oh_q <= legal_new ? (8'd1 << ph_new) : 8'd0;
            step_q     <= step_d;
            rev_q      <= rev_d;
            err_q      <= err_d;
        end
    end

    // Status counters. A same-cycle clear is applied first, so the event still counts.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rev_cnt_q    <= '0;
            err_cnt_q    <= 8'd0;
            err_sticky_q <= 1'b0;
        end else begin
            if (rev_d)        rev_cnt_q <= (bus.clr ? '0 : rev_cnt_q) + REV_W'(1);
            else if (bus.clr) rev_cnt_q <= '0;

            if (err_d) begin
                err_cnt_q    <= bus.clr ? 8'd1 : sat_inc8(err_cnt_q);
                err_sticky_q <= 1'b1;
            end else if (bus.clr) begin
                err_cnt_q    <= 8'd0;
                err_sticky_q <= 1'b0;
            end
        end
    end

    assign bus.phase      = phase_q;
    assign bus.phase_oh   = phase_oh_q;
    assign bus.step       = step_q;
    assign bus.rev        = rev_q;
    assign bus.rev_cnt    = rev_cnt_q;
    assign bus.lock       = (state_q == LOCK);
    assign bus.err        = err_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
endmodule

// File: tb/tb_jhson_monitor.sv
// Bench for jhson_monitor with two instances sharing one stimulus stream.
// Instance A uses LOCK_CNT=4, REV_W=8. Instance B uses LOCK_CNT=1, REV_W=2.
// Each instance is compared every cycle against a behavioural model built
// from the code table and the lock/revolution/error rules.
module tb_jhson_monitor;
    logic clk;
    logic n_rst;

    jhson_monitor_if #(.REV_W(8)) ifa ();
    jhson_monitor_if #(.REV_W(2)) ifb ();

    jhson_monitor #(.LOCK_CNT(4), .REV_W(8)) dut_a (.clk(clk), .n_rst(n_rst), .bus(ifa));
    jhson_monitor #(.LOCK_CNT(1), .REV_W(2)) dut_b (.clk(clk), .n_rst(n_rst), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int run;      // -1 while searching, else clean advances seen since acquisition
        int prev;     // phase of last sample, -1 if it was illegal
        int phase;
        int phase_oh;
        int step;
        int rev;
        int rev_cnt;
        int lock;
        int err;
        int sticky;
        int err_cnt;
    } mdl_t;

    mdl_t ma, mb;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cur    = 0;

    function automatic logic [3:0] jcode(input int p);
        case (p)
            0: jcode = 4'b0000;
            1: jcode = 4'b1000;
            2: jcode = 4'b1100;
            3: jcode = 4'b1110;
            4: jcode = 4'b1111;
            5: jcode = 4'b0111;
            6: jcode = 4'b0011;
            default: jcode = 4'b0001;
        endcase
    endfunction

    function automatic int jlookup(input logic [3:0] c);
        jlookup = -1;
        for (int i = 0; i < 8; i++)
            if (jcode(i) == c) jlookup = i;
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.run = -1; m.prev = -1;
        m.phase = 0; m.phase_oh = 0; m.step = 0; m.rev = 0; m.rev_cnt = 0;
        m.lock = 0; m.err = 0; m.sticky = 0; m.err_cnt = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t mi, input logic [3:0] code,
                                      input logic clr, input int lock_cnt, input int rev_w);
        mdl_t m;
        int idx;
        bit adv, hold;
        m   = mi;
        idx = jlookup(code);
        adv  = (idx >= 0) && (m.prev >= 0) && (idx == (m.prev + 1) % 8);
        hold = (idx >= 0) && (idx == m.prev);
        m.step = 0; m.rev = 0; m.err = 0;
        if (m.run < 0) begin
            if (idx >= 0) m.run = 0;
        end else if (m.run < lock_cnt) begin
            if (adv) begin m.step = 1; m.run++; end
            else if (!hold) m.run = -1;
        end else begin
            if (adv) begin m.step = 1; if (idx == 0) m.rev = 1; end
            else if (!hold) begin m.err = 1; m.run = -1; end
        end
        m.lock = (m.run >= lock_cnt) ? 1 : 0;
        if (clr) begin m.rev_cnt = 0; m.err_cnt = 0; m.sticky = 0; end
        if (m.rev) m.rev_cnt = (m.rev_cnt + 1) % (1 << rev_w);
        if (m.err) begin
            m.sticky = 1;
            if (m.err_cnt < 255) m.err_cnt++;
        end
        if (idx >= 0) m.phase = idx;
        m.phase_oh = (idx >= 0) ? (1 << idx) : 0;
        m.prev = idx;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        chk("a.phase",      32'(ifa.phase),      ma.phase);
        chk("a.phase_oh",   32'(ifa.phase_oh),   ma.phase_oh);
        chk("a.step",       32'(ifa.step),       ma.step);
        chk("a.rev",        32'(ifa.rev),        ma.rev);
        chk("a.rev_cnt",    32'(ifa.rev_cnt),    ma.rev_cnt);
        chk("a.lock",       32'(ifa.lock),       ma.lock);
        chk("a.err",        32'(ifa.err),        ma.err);
        chk("a.err_sticky", 32'(ifa.err_sticky), ma.sticky);
        chk("a.err_cnt",    32'(ifa.err_cnt),    ma.err_cnt);
        chk("b.phase",      32'(ifb.phase),      mb.phase);
        chk("b.phase_oh",   32'(ifb.phase_oh),   mb.phase_oh);
        chk("b.step",       32'(ifb.step),       mb.step);
        chk("b.rev",        32'(ifb.rev),        mb.rev);
        chk("b.rev_cnt",    32'(ifb.rev_cnt),    mb.rev_cnt);
        chk("b.lock",       32'(ifb.lock),       mb.lock);
        chk("b.err",        32'(ifb.err),        mb.err);
        chk("b.err_sticky", 32'(ifb.err_sticky), mb.sticky);
        chk("b.err_cnt",    32'(ifb.err_cnt),    mb.err_cnt);
    endtask

    task automatic tick(input logic [3:0] c, input logic cl);
        ifa.in_a = c; ifb.in_a = c;
        ifa.clr  = cl; ifb.clr  = cl;
        @(posedge clk);
        ma = mdl_step(ma, c, cl, 4, 8);
        mb = mdl_step(mb, c, cl, 1, 2);
        #1;
        check_all();
    endtask

    task automatic adv_n(input int n);
        for (int i = 0; i < n; i++) begin
            cur = (cur + 1) % 8;
            tick(jcode(cur), 1'b0);
        end
    endtask

    initial begin
        int steps;
        int b_before;
        int r;
        logic [3:0] c;

        n_rst = 1'b0;
        ifa.in_a = 4'b0000; ifb.in_a = 4'b0000;
        ifa.clr  = 1'b0;    ifb.clr  = 1'b0;
        ma = mdl_reset(); mb = mdl_reset();
        #12;
        check_all();
        chk("rst.lock", 32'(ifa.lock), 0);
        n_rst = 1'b1;

        // Lock acquisition from 0000
        cur = 0;
        tick(jcode(0), 1'b0);
        chk("acq.lock_e1", 32'(ifa.lock), 0);
        for (int e = 2; e <= 12; e++) begin
            adv_n(1);
            if (e <= 9) chk("acq.step", 32'(ifa.step), 1);
            if (e == 4) chk("acq.lock_e4", 32'(ifa.lock), 0);
            if (e == 5) chk("acq.lock_e5", 32'(ifa.lock), 1);
            if (e == 8) chk("acq.rev_e8", 32'(ifa.rev), 0);
            if (e == 9) begin
                chk("acq.rev_e9", 32'(ifa.rev), 1);
                chk("acq.rev_cnt_e9", 32'(ifa.rev_cnt), 1);
                chk("acq.err_cnt", 32'(ifa.err_cnt), 0);
            end
        end

        // Skip error: 1100 followed by 1111
        while (cur != 2) adv_n(1);
        cur = 4;
        tick(jcode(4), 1'b0);
        chk("skip.err", 32'(ifa.err), 1);
        chk("skip.lock", 32'(ifa.lock), 0);
        chk("skip.err_cnt", 32'(ifa.err_cnt), 1);
        chk("skip.sticky", 32'(ifa.err_sticky), 1);
        chk("skip.phase", 32'(ifa.phase), 4);
        adv_n(4);
        chk("skip.relock4", 32'(ifa.lock), 0);
        adv_n(1);
        chk("skip.relock5", 32'(ifa.lock), 1);

        // Illegal code while locked
        tick(4'b1010, 1'b0);
        chk("ill.phase_oh", 32'(ifa.phase_oh), 0);
        chk("ill.phase", 32'(ifa.phase), 32'(cur));
        chk("ill.err", 32'(ifa.err), 1);
        chk("ill.lock", 32'(ifa.lock), 0);
        cur = 0;
        tick(jcode(0), 1'b0);
        chk("ill.acq_no_lock", 32'(ifa.lock), 0);
        adv_n(4);
        chk("ill.relock", 32'(ifa.lock), 1);

        // Holds: each code repeated three cycles
        steps = 0;
        for (int i = 0; i < 16; i++) begin
            adv_n(1);
            steps += int'(ifb.step);
            repeat (2) begin
                tick(jcode(cur), 1'b0);
                steps += int'(ifb.step);
            end
        end
        chk("hold.steps", 32'(steps), 16);
        chk("hold.lock_b", 32'(ifb.lock), 1);

        // Revolution counter wrap on the 2-bit instance
        b_before = int'(ifb.rev_cnt);
        adv_n(40);
        chk("wrap.rev_cnt_b", 32'(ifb.rev_cnt), 32'((b_before + 5) % 4));

        // Error count saturation: skip errors, re-locking in between
        for (int k = 0; k < 260; k++) begin
            cur = (cur + 2) % 8;
            tick(jcode(cur), 1'b0);
            adv_n(6);
        end
        chk("sat.err_cnt", 32'(ifa.err_cnt), 255);
        chk("sat.sticky", 32'(ifa.err_sticky), 1);

        // Clear colliding with a revolution
        while (cur != 7) adv_n(1);
        cur = 0;
        tick(jcode(0), 1'b1);
        chk("clr.rev_cnt_a", 32'(ifa.rev_cnt), 1);
        chk("clr.rev_cnt_b", 32'(ifb.rev_cnt), 1);
        chk("clr.err_cnt", 32'(ifa.err_cnt), 0);

        // Clear colliding with an error
        adv_n(5);
        cur = (cur + 3) % 8;
        tick(jcode(cur), 1'b1);
        chk("clr.err_cnt_ev", 32'(ifa.err_cnt), 1);
        chk("clr.sticky_ev", 32'(ifa.err_sticky), 1);

        // Reset mid-revolution
        adv_n(9);
        #2;
        n_rst = 1'b0;
        #1;
        ma = mdl_reset(); mb = mdl_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        n_rst = 1'b1;
        cur = 0;
        tick(jcode(0), 1'b0);
        for (int e = 2; e <= 9; e++) begin
            adv_n(1);
            if (e == 4) chk("rrst.lock_e4", 32'(ifa.lock), 0);
            if (e == 5) chk("rrst.lock_e5", 32'(ifa.lock), 1);
            if (e == 9) chk("rrst.rev_cnt", 32'(ifa.rev_cnt), 1);
        end

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70) begin
                cur = (cur + 1) % 8;
                c = jcode(cur);
            end else if (r < 85) begin
                c = jcode(cur);
            end else begin
                c = 4'($urandom_range(0, 15));
                if (jlookup(c) >= 0) cur = jlookup(c);
            end
            tick(c, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
